// File: rtl/titan_wb_arbiter.sv
// titan_wb_arbiter: two-master Wishbone arbiter sharing one memory bus between
// the Titan LSU instruction port and data port. Round-robin on ties, grant held
// for the whole cyc, responses routed to the granted master only, and a
// watchdog that errors out transfers the slave never answers.
module titan_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction master (read-only)
  input  logic [31:0] iaddr_i,
  input  logic        icyc_i,
  input  logic        istb_i,
  output logic [31:0] idat_o,
  output logic        iack_o,
  output logic        ierr_o,
  // data master
  input  logic [31:0] daddr_i,
  input  logic [31:0] ddat_i,
  input  logic [3:0]  dsel_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  input  logic        dwe_i,
  output logic [31:0] ddat_o,
  output logic        dack_o,
  output logic        derr_o,
  // shared slave side
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  // current grant, one-hot: bit 0 instruction, bit 1 data
  output logic [1:0]  gnt_o
);

  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t        state_q;
  logic          last_d_q;   // 1: data master was granted last, 0: instruction
  logic [CW-1:0] cnt_q;
  logic [1:0]    gnt_q;

  logic ireq, dreq;
  logic sel_i, sel_d;
  logic cur_cyc, cur_stb;
  logic wd_hit;

  assign ireq  = icyc_i & istb_i;
  assign dreq  = dcyc_i & dstb_i;
  assign sel_i = (state_q == GNT_I);
  assign sel_d = (state_q == GNT_D);

  // Signals of whichever master currently owns the bus.
  assign cur_cyc = (sel_i & icyc_i) | (sel_d & dcyc_i);
  assign cur_stb = (sel_i & istb_i) | (sel_d & dstb_i);

  // Watchdog expiry: a slave response in the same cycle takes priority.
  assign wd_hit = WD_EN && (sel_i || sel_d) && (cnt_q == WD_LIMIT)
                  && !wb_ack_i && !wb_err_i;

  // Slave request mux: combinational so a grant adds no latency and a dropped
  // master cyc reaches the slave in the same cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wb_addr_o = '0;
    wb_dat_o  = '0;
    wb_sel_o  = '0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    case (state_q)
      GNT_I: begin
        wb_addr_o = iaddr_i;
        wb_sel_o  = 4'hf;
        wb_cyc_o  = icyc_i & ~wd_hit;
        wb_stb_o  = istb_i & ~wd_hit;
      end
      GNT_D: begin
        wb_addr_o = daddr_i;
        wb_dat_o  = ddat_i;
        wb_sel_o  = dsel_i;
        wb_we_o   = dwe_i;
        wb_cyc_o  = dcyc_i & ~wd_hit;
        wb_stb_o  = dstb_i & ~wd_hit;
      end
      default: ;
    endcase
  end

  // Response routing: data is broadcast, handshakes only reach the owner.
  assign idat_o = wb_dat_i;
  assign ddat_o = wb_dat_i;
  assign iack_o = wb_ack_i & sel_i;
  assign dack_o = wb_ack_i & sel_d;
  assign ierr_o = (wb_err_i | wd_hit) & sel_i;
  assign derr_o = (wb_err_i | wd_hit) & sel_d;
  assign gnt_o  = gnt_q;

  // Arbitration FSM with round-robin tie break, grant lock and watchdog count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (dreq && (!ireq || !last_d_q)) begin
            state_q  <= GNT_D;
            last_d_q <= 1'b1;
            gnt_q    <= 2'b10;
          end else if (ireq) begin
            state_q  <= GNT_I;
            last_d_q <= 1'b0;
            gnt_q    <= 2'b01;
          end
        end
        GNT_I, GNT_D: begin
          if (!cur_cyc || wd_hit) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            cnt_q   <= '0;
          end else if (wb_ack_i || wb_err_i) begin
            cnt_q <= '0;
          end else if (cur_stb && WD_EN) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_titan_wb_arbiter.sv
// Directed self-checking bench for titan_wb_arbiter (TIMEOUT = 4).
// Inputs change 1 ns after each rising edge; outputs are sampled 4 ns after.
module tb_titan_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] iaddr_i, daddr_i, ddat_i, wb_dat_i;
  logic        icyc_i, istb_i, dcyc_i, dstb_i, dwe_i, wb_ack_i, wb_err_i;
  logic [3:0]  dsel_i;
  logic [31:0] idat_o, ddat_o, wb_addr_o, wb_dat_o;
  logic        iack_o, ierr_o, dack_o, derr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [1:0]  gnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  titan_wb_arbiter #(.TIMEOUT(4), .CW(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iaddr_i(iaddr_i), .icyc_i(icyc_i), .istb_i(istb_i),
    .idat_o(idat_o), .iack_o(iack_o), .ierr_o(ierr_o),
    .daddr_i(daddr_i), .ddat_i(ddat_i), .dsel_i(dsel_i),
    .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i),
    .ddat_o(ddat_o), .dack_o(dack_o), .derr_o(derr_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the drive point of the next cycle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Move from the drive point to the sample point of the same cycle.
  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    iaddr_i = '0; icyc_i = 0; istb_i = 0;
    daddr_i = '0; ddat_i = '0; dsel_i = '0; dcyc_i = 0; dstb_i = 0; dwe_i = 0;
    wb_dat_i = '0; wb_ack_i = 0; wb_err_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    #2;
    // ---------- reset state ----------
    wb_ack_i = 1; wb_err_i = 1;
    #1;
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_wb_cyc", wb_cyc_o, 0);
    check("rst_wb_stb", wb_stb_o, 0);
    check("rst_wb_addr", wb_addr_o, 0);
    check("rst_acks", {iack_o, ierr_o, dack_o, derr_o}, 4'b0000);
    do_reset();

    // ---------- single data write ----------
    dcyc_i = 1; dstb_i = 1; daddr_i = 32'h100; ddat_i = 32'hDEADBEEF;
    dsel_i = 4'h3; dwe_i = 1;
    settle();
    check("wr_c0_gnt", gnt_o, 2'b00);
    check("wr_c0_cyc", wb_cyc_o, 0);
    tick();
    settle();
    check("wr_c1_gnt", gnt_o, 2'b10);
    check("wr_c1_addr", wb_addr_o, 32'h100);
    check("wr_c1_dat", wb_dat_o, 32'hDEADBEEF);
    check("wr_c1_sel", wb_sel_o, 4'h3);
    check("wr_c1_ctl", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b111);
    check("wr_c1_dack", dack_o, 0);
    tick();
    wb_ack_i = 1; wb_dat_i = 32'h0BADF00D;
    settle();
    check("wr_c2_gnt", gnt_o, 2'b10);
    check("wr_c2_dack", dack_o, 1);
    check("wr_c2_iack", iack_o, 0);
    check("wr_c2_ddat", ddat_o, 32'h0BADF00D);
    check("wr_c2_idat", idat_o, 32'h0BADF00D);
    tick();
    wb_ack_i = 0; dcyc_i = 0; dstb_i = 0;
    settle();
    check("wr_c3_dack", dack_o, 0);
    check("wr_c3_cyc", wb_cyc_o, 0);
    tick();
    settle();
    check("wr_c4_gnt", gnt_o, 2'b00);

    // ---------- tie round-robin: D, I, D, I ----------
    do_reset();
    iaddr_i = 32'h40; daddr_i = 32'h80;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      icyc_i = 1; istb_i = 1; dcyc_i = 1; dstb_i = 1;
      settle();
      check($sformatf("rr%0d_idle", k), gnt_o, 2'b00);
      tick();
      wb_ack_i = 1;
      settle();
      check($sformatf("rr%0d_gnt", k), gnt_o, exp_g);
      check($sformatf("rr%0d_acks", k), {dack_o, iack_o}, exp_g);
      check($sformatf("rr%0d_addr", k), wb_addr_o, exp_g[1] ? 32'h80 : 32'h40);
      tick();
      wb_ack_i = 0;
      if (exp_g[1]) begin dcyc_i = 0; dstb_i = 0; end
      else begin icyc_i = 0; istb_i = 0; end
      settle();
      check($sformatf("rr%0d_hold", k), gnt_o, exp_g);
      check($sformatf("rr%0d_rel_cyc", k), wb_cyc_o, 0);
      tick();
    end

    // ---------- lock during multi-beat data cycle ----------
    do_reset();
    iaddr_i = 32'h1234; daddr_i = 32'h5678;
    icyc_i = 1; istb_i = 1; dcyc_i = 1; dstb_i = 1;
    tick();
    for (int b = 0; b < 3; b++) begin
      wb_ack_i = 1;
      settle();
      check($sformatf("lock_b%0d_gnt", b), gnt_o, 2'b10);
      check($sformatf("lock_b%0d_iack", b), iack_o, 0);
      tick();
    end
    wb_ack_i = 0; dcyc_i = 0; dstb_i = 0;
    settle();
    check("lock_drop_gnt", gnt_o, 2'b10);
    tick();
    settle();
    check("lock_bubble", gnt_o, 2'b00);
    tick();
    settle();
    check("lock_i_gnt", gnt_o, 2'b01);
    check("lock_i_addr", wb_addr_o, 32'h1234);
    check("lock_i_selwe", {wb_sel_o, wb_we_o}, 5'b11110);
    check("lock_i_dat", wb_dat_o, 0);
    tick();
    icyc_i = 0; istb_i = 0;
    tick();

    // ---------- watchdog expiry, then ack on the limit cycle ----------
    do_reset();
    icyc_i = 1; istb_i = 1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      settle();
      check($sformatf("wd_c%0d_ierr", c), ierr_o, 0);
      check($sformatf("wd_c%0d_cyc", c), wb_cyc_o, 1);
      tick();
    end
    settle();
    check("wd_c5_ierr", ierr_o, 1);
    check("wd_c5_derr", derr_o, 0);
    check("wd_c5_cycstb", {wb_cyc_o, wb_stb_o}, 2'b00);
    check("wd_c5_gnt", gnt_o, 2'b01);
    tick();
    settle();
    check("wd_c6_idle", gnt_o, 2'b00);
    check("wd_c6_ierr", ierr_o, 0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      settle();
      check($sformatf("wd2_c%0d_ierr", c), ierr_o, 0);
      tick();
    end
    wb_ack_i = 1;
    settle();
    check("wd2_c5_iack", iack_o, 1);
    check("wd2_c5_ierr", ierr_o, 0);
    check("wd2_c5_cyc", wb_cyc_o, 1);
    tick();
    wb_ack_i = 0; icyc_i = 0; istb_i = 0;
    settle();
    check("wd2_c6_gnt", gnt_o, 2'b01);
    tick();

    // ---------- kill: master drops cyc, late ack discarded ----------
    do_reset();
    icyc_i = 1; istb_i = 1;
    tick();
    settle();
    check("kill_c1_gnt", gnt_o, 2'b01);
    tick();
    icyc_i = 0; istb_i = 0;
    settle();
    check("kill_c2_cyc", wb_cyc_o, 0);
    tick();
    wb_ack_i = 1;
    settle();
    check("kill_c3_iack", iack_o, 0);
    check("kill_c3_dack", dack_o, 0);
    check("kill_c3_gnt", gnt_o, 2'b00);
    tick();
    wb_ack_i = 0;

    // ---------- asynchronous reset mid-grant ----------
    do_reset();
    dcyc_i = 1; dstb_i = 1;
    tick();
    settle();
    check("arst_pre_cyc", wb_cyc_o, 1);
    tick();
    wb_ack_i = 1;
    #1 rst_i = 1'b1;
    #1;
    check("arst_cyc", wb_cyc_o, 0);
    check("arst_gnt", gnt_o, 2'b00);
    check("arst_dack", dack_o, 0);
    rst_i = 1'b0;
    wb_ack_i = 0;
    icyc_i = 1; istb_i = 1;
    tick();
    settle();
    check("arst_tie_gnt", gnt_o, 2'b10);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
